// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction BSRAM between CPU fetch (read-only) and the
// loader/debug port (read/write), with starvation relief for fetch and a loader lock.
module imem_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              ld_lock,
    output logic              ld_lock_ack,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic              mem_reset,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOCK_PEND = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        starve_cnt;
    logic              tag_vld;
    logic              tag_ld;
    logic [ADDR_W-1:0] ad_hold;
    logic [DATA_W-1:0] din_hold;
    logic [DATA_W-1:0] fetch_rdata_hold;
    logic [DATA_W-1:0] ld_rdata_hold;
    logic              starve_hit;
    logic              fetch_in_flight;

    assign starve_hit      = (starve_cnt == 8'(STARVE_MAX));
    assign fetch_in_flight = tag_vld && !tag_ld;

    // A rising ld_lock already blocks fetch in RUN so no new fetch read slips in.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (!reset) begin
            if (state == RUN) begin
                fetch_gnt = fetch_req && !ld_lock && (!ld_req || starve_hit);
                ld_gnt    = ld_req && !fetch_gnt;
            end else begin
                ld_gnt = ld_req;
            end
        end
    end

    assign ld_lock_ack = (state == LOCKED) && ld_lock;

    assign mem_ce    = fetch_gnt | ld_gnt;
    assign mem_wre   = ld_gnt & ld_we;
    assign mem_oce   = 1'b1;
    assign mem_reset = reset;
    assign mem_ad    = fetch_gnt ? fetch_addr : (ld_gnt ? ld_addr : ad_hold);
    assign mem_din   = fetch_gnt ? '0 : (ld_gnt ? ld_wdata : din_hold);

    // Read data arrives one cycle after the grant; the tag says whose it is.
    assign fetch_rvalid = tag_vld && !tag_ld;
    assign ld_rvalid    = tag_vld && tag_ld;
    assign fetch_rdata  = fetch_rvalid ? mem_dout : fetch_rdata_hold;
    assign ld_rdata     = ld_rvalid ? mem_dout : ld_rdata_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= RUN;
            starve_cnt       <= '0;
            tag_vld          <= 1'b0;
            tag_ld           <= 1'b0;
            ad_hold          <= '0;
            din_hold         <= '0;
            fetch_rdata_hold <= '0;
            ld_rdata_hold    <= '0;
        end else begin
            tag_vld <= (fetch_gnt | (ld_gnt & !ld_we));
            tag_ld  <= ld_gnt;
            if (mem_ce) begin
                ad_hold  <= mem_ad;
                din_hold <= mem_din;
            end
            if (fetch_rvalid) fetch_rdata_hold <= mem_dout;
            if (ld_rvalid)    ld_rdata_hold    <= mem_dout;

            // The counter only runs in RUN so it is already zero on entry to LOCKED.
            if (state != RUN || !fetch_req || fetch_gnt)
                starve_cnt <= '0;
            else if (starve_cnt != 8'hFF)
                starve_cnt <= starve_cnt + 8'd1;

            case (state)
                RUN:       if (ld_lock) state <= LOCK_PEND;
                LOCK_PEND: begin
                    if (!ld_lock)              state <= RUN;
                    else if (!fetch_in_flight) state <= LOCKED;
                end
                LOCKED:    if (!ld_lock) state <= RUN;
                default:   state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 2048x32 BSRAM preloaded
// with 0xA0000000 + address.
module tb_imem_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam logic [31:0] BASE = 32'hA000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_lock;
    logic              ld_lock_ack;
    logic              mem_ce;
    logic              mem_oce;
    logic              mem_wre;
    logic              mem_reset;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic [DATA_W-1:0] ram [0:2047];
    int n_checks = 0;
    int n_fail   = 0;

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ld_lock(ld_lock), .ld_lock_ack(ld_lock_ack),
        .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre), .mem_reset(mem_reset),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Single-port BSRAM, bypass read mode: dout registered one cycle after a read.
    always @(posedge clk or posedge mem_reset) begin
        if (mem_reset) mem_dout <= '0;
        else if (mem_ce) begin
            if (mem_wre) ram[mem_ad] <= mem_din;
            else         mem_dout    <= ram[mem_ad];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic              exp_f;
        logic              prev_f;
        logic [ADDR_W-1:0] prev_ld;
        logic [ADDR_W-1:0] next_ld;

        for (int i = 0; i < 2048; i++) ram[i] = BASE + 32'(i);
        reset = 1'b1; fetch_req = 0; fetch_addr = '0; ld_req = 0; ld_we = 0;
        ld_addr = '0; ld_wdata = '0; ld_lock = 0;
        #3;
        chk("rst_fetch_gnt", 32'(fetch_gnt), 0);
        chk("rst_ld_gnt", 32'(ld_gnt), 0);
        chk("rst_fetch_rvalid", 32'(fetch_rvalid), 0);
        chk("rst_ld_rvalid", 32'(ld_rvalid), 0);
        chk("rst_ack", 32'(ld_lock_ack), 0);
        chk("rst_mem_ce", 32'(mem_ce), 0);
        chk("rst_mem_wre", 32'(mem_wre), 0);
        chk("rst_mem_ad", 32'(mem_ad), 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_fetch_rdata", fetch_rdata, 0);
        chk("rst_ld_rdata", ld_rdata, 0);
        chk("rst_mem_reset", 32'(mem_reset), 1);
        chk("rst_mem_oce", 32'(mem_oce), 1);
        tick();
        reset = 1'b0;

        // Fetch only, addresses 0,1,2 back to back
        fetch_req = 1; fetch_addr = 0; #1;
        chk("s1_gnt0", 32'(fetch_gnt), 1);
        chk("s1_ad0", 32'(mem_ad), 0);
        tick(); fetch_addr = 1; #1;
        chk("s1_gnt1", 32'(fetch_gnt), 1);
        chk("s1_rv0", 32'(fetch_rvalid), 1);
        chk("s1_rd0", fetch_rdata, BASE + 0);
        chk("s1_ldrv0", 32'(ld_rvalid), 0);
        tick(); fetch_addr = 2; #1;
        chk("s1_gnt2", 32'(fetch_gnt), 1);
        chk("s1_rd1", fetch_rdata, BASE + 1);
        chk("s1_ldrv1", 32'(ld_rvalid), 0);
        tick(); fetch_req = 0; #1;
        chk("s1_gnt_off", 32'(fetch_gnt), 0);
        chk("s1_rv2", 32'(fetch_rvalid), 1);
        chk("s1_rd2", fetch_rdata, BASE + 2);
        tick();
        chk("s1_rv_off", 32'(fetch_rvalid), 0);
        chk("s1_rd_hold", fetch_rdata, BASE + 2);

        // Idle for 10 cycles: memory stays quiet, address held
        for (int c = 0; c < 10; c++) begin
            chk("s6_ce", 32'(mem_ce), 0);
            chk("s6_wre", 32'(mem_wre), 0);
            chk("s6_ad", 32'(mem_ad), 2);
            chk("s6_starve", 32'(dut.starve_cnt), 0);
            tick();
        end

        // Loader write then fetch read of the same word
        ld_req = 1; ld_we = 1; ld_addr = 11'h005; ld_wdata = 32'hDEADBEEF; #1;
        chk("s3_ld_gnt", 32'(ld_gnt), 1);
        chk("s3_wre", 32'(mem_wre), 1);
        chk("s3_ad", 32'(mem_ad), 5);
        chk("s3_din", mem_din, 32'hDEADBEEF);
        tick(); ld_req = 0; ld_we = 0; fetch_req = 1; fetch_addr = 11'h005; #1;
        chk("s3_wre_once", 32'(mem_wre), 0);
        chk("s3_fgnt", 32'(fetch_gnt), 1);
        chk("s3_no_ldrv", 32'(ld_rvalid), 0);
        chk("s3_no_frv", 32'(fetch_rvalid), 0);
        tick(); fetch_req = 0; #1;
        chk("s3_frv", 32'(fetch_rvalid), 1);
        chk("s3_frd", fetch_rdata, 32'hDEADBEEF);
        tick();

        // Contention: loader wins 8 cycles, fetch forced on cycle 9, loader again
        ld_req = 1; ld_we = 0; fetch_req = 1; fetch_addr = 11'd32;
        next_ld = 11'd16; prev_f = 0; prev_ld = '0;
        for (int c = 1; c <= 10; c++) begin
            ld_addr = next_ld; #1;
            exp_f = (c == 9);
            chk("s2_fgnt", 32'(fetch_gnt), 32'(exp_f));
            chk("s2_lgnt", 32'(ld_gnt), 32'(!exp_f));
            if (c > 1) begin
                if (prev_f) begin
                    chk("s2_frv", 32'(fetch_rvalid), 1);
                    chk("s2_frd", fetch_rdata, BASE + 32);
                    chk("s2_lrv_off", 32'(ld_rvalid), 0);
                end else begin
                    chk("s2_lrv", 32'(ld_rvalid), 1);
                    chk("s2_lrd", ld_rdata, BASE + 32'(prev_ld));
                    chk("s2_frv_off", 32'(fetch_rvalid), 0);
                end
            end
            prev_f = exp_f;
            prev_ld = ld_addr;
            if (!exp_f) next_ld = next_ld + 11'd1;
            tick();
        end
        ld_req = 0; fetch_req = 0; #1;
        chk("s2_last_lrv", 32'(ld_rvalid), 1);
        chk("s2_last_lrd", ld_rdata, BASE + 32'(prev_ld));
        tick();

        // Lock with a fetch read in flight
        fetch_req = 1; fetch_addr = 11'd7; #1;
        chk("s4_fgnt", 32'(fetch_gnt), 1);
        tick(); ld_lock = 1; #1;
        chk("s4_frv", 32'(fetch_rvalid), 1);
        chk("s4_frd", fetch_rdata, BASE + 7);
        chk("s4_fgnt_blk", 32'(fetch_gnt), 0);
        chk("s4_ack_early", 32'(ld_lock_ack), 0);
        tick();
        chk("s4_pend_ack", 32'(ld_lock_ack), 0);
        chk("s4_pend_fgnt", 32'(fetch_gnt), 0);
        tick();
        chk("s4_ack", 32'(ld_lock_ack), 1);
        chk("s4_lock_fgnt", 32'(fetch_gnt), 0);
        chk("s4_starve0", 32'(dut.starve_cnt), 0);
        ld_req = 1; ld_we = 1; ld_addr = 11'd9; ld_wdata = 32'h1234_5678; #1;
        chk("s4_lgnt", 32'(ld_gnt), 1);
        chk("s4_lock_fgnt2", 32'(fetch_gnt), 0);
        tick(); ld_req = 0; ld_we = 0;
        chk("s4_ack_hold", 32'(ld_lock_ack), 1);
        ld_lock = 0; fetch_addr = 11'd9; #1;
        chk("s4_ack_drop", 32'(ld_lock_ack), 0);
        chk("s4_fgnt_wait", 32'(fetch_gnt), 0);
        tick();
        chk("s4_fgnt_resume", 32'(fetch_gnt), 1);
        tick(); fetch_req = 0; #1;
        chk("s4_frv2", 32'(fetch_rvalid), 1);
        chk("s4_frd2", fetch_rdata, 32'h1234_5678);
        tick();

        // Both requests arriving together with a rising lock
        fetch_req = 1; ld_req = 1; ld_addr = 11'd4; ld_lock = 1; #1;
        chk("sim_lgnt", 32'(ld_gnt), 1);
        chk("sim_fgnt", 32'(fetch_gnt), 0);
        tick(); fetch_req = 0; ld_req = 0; ld_lock = 0;
        tick();
        tick();

        // Asynchronous reset right after a loader read grant
        ld_req = 1; ld_addr = 11'd3; #1;
        chk("s5_lgnt", 32'(ld_gnt), 1);
        tick(); ld_req = 0;
        #2 reset = 1; #1;
        chk("s5_lrv", 32'(ld_rvalid), 0);
        chk("s5_lrd", ld_rdata, 0);
        chk("s5_ce", 32'(mem_ce), 0);
        chk("s5_ad", 32'(mem_ad), 0);
        chk("s5_frd", fetch_rdata, 0);
        tick();
        chk("s5_lrv_hold", 32'(ld_rvalid), 0);
        reset = 0; fetch_req = 1; fetch_addr = 0; #1;
        chk("s5_fgnt", 32'(fetch_gnt), 1);
        tick(); fetch_req = 0; #1;
        chk("s5_frv", 32'(fetch_rvalid), 1);
        chk("s5_frd0", fetch_rdata, BASE + 0);
        chk("s5_lrv_after", 32'(ld_rvalid), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
